// File: rtl/cmd_pad_receiver.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// cmd_pad_receiver
// Host-side deserializer for the SD CMD line. Once armed it waits for the
// card's start bit, shifts in a 48-bit (R1/R3/R6/R7) or 136-bit (R2) response
// MSB-first, checks CRC7 and the end bit, and presents the frame. If no start
// bit arrives within the NCR window it reports no_response instead.
//
// Ports
//   sd_clock            in   sole clock, rising edge
//   reset               in   asynchronous, active-low
//   enable_rx           in   level: 1 arms, 0 aborts or acknowledges
//   long_response       in   latched at arm: 1 = LONG_BITS, 0 = SHORT_BITS
//   cmd_pin_in          in   serial CMD line, idles high
//   pad_response        out  received frame, short frames right-aligned
//   reception_complete  out  frame received, held until enable_rx=0
//   no_response         out  start-bit timeout, held until enable_rx=0
//   crc_error           out  CRC7 mismatch or bad end bit (with complete)
//   busy                out  1 while waiting for start bit or receiving
//
// Handshake: enable_rx is a level. Raising it in IDLE arms the receiver;
// result flags (reception_complete / no_response) stay up until enable_rx
// drops, which returns to IDLE on that edge. IDLE always lasts >= 1 cycle.
// ---------------------------------------------------------------------------
module cmd_pad_receiver #(
   parameter int TIMEOUT_CYCLES = 64,
   parameter int SHORT_BITS     = 48,
   parameter int LONG_BITS      = 136
) (
   input  logic                 sd_clock,
   input  logic                 reset,
   input  logic                 enable_rx,
   input  logic                 long_response,
   input  logic                 cmd_pin_in,
   output logic [LONG_BITS-1:0] pad_response,
   output logic                 reception_complete,
   output logic                 no_response,
   output logic                 crc_error,
   output logic                 busy
);

   localparam int         TW      = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [7:0] SHORT_N = 8'(SHORT_BITS);
   localparam logic [7:0] LONG_N  = 8'(LONG_BITS);

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      WAIT_START = 2'd1,
      RECEIVE    = 2'd2,
      DONE       = 2'd3
   } state_t;

   state_t                 state_q;
   logic                   long_q;
   logic                   pend_q;     // frame captured, results publish next edge
   logic [LONG_BITS-1:0]   shift_q;
   logic [7:0]             bit_cnt_q;
   logic [TW-1:0]          tmo_cnt_q;
   logic [6:0]             crc_q;
   logic [LONG_BITS-1:0]   pad_q;
   logic                   complete_q;
   logic                   no_resp_q;
   logic                   crc_err_q;
   logic                   busy_q;

   logic [7:0]             bit_num_d;
   logic [7:0]             frame_len;
   logic                   in_crc;
   logic                   crc_fb;
   logic [6:0]             crc_d;
   logic [LONG_BITS-1:0]   shift_d;

   // bit_num_d is the 1-based position of the bit sampled on this edge.
   // Frame bit index is frame_len - bit_num; CRC covers indices down to 8,
   // and for long frames stops at 127 (the leading 8 bits are excluded).
   always_comb begin
      bit_num_d = bit_cnt_q + 8'd1;
      frame_len = long_q ? LONG_N : SHORT_N;
      in_crc    = 1'b0;
      if (long_q) begin
         in_crc = (bit_num_d >= (frame_len - 8'd127)) &&
                  (bit_num_d <= (frame_len - 8'd8));
      end else begin
         in_crc = (bit_num_d <= (frame_len - 8'd8));
      end
      // Serial CRC7, polynomial x^7 + x^3 + 1.
      crc_fb  = cmd_pin_in ^ crc_q[6];
      crc_d   = in_crc ? ({crc_q[5:0], 1'b0} ^ {3'b000, crc_fb, 2'b00, crc_fb}) : crc_q;
      shift_d = {shift_q[LONG_BITS-2:0], cmd_pin_in};
   end

   always_ff @(posedge sd_clock or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         long_q     <= 1'b0;
         pend_q     <= 1'b0;
         shift_q    <= '0;
         bit_cnt_q  <= '0;
         tmo_cnt_q  <= '0;
         crc_q      <= '0;
         pad_q      <= '0;
         complete_q <= 1'b0;
         no_resp_q  <= 1'b0;
         crc_err_q  <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               complete_q <= 1'b0;
               no_resp_q  <= 1'b0;
               pend_q     <= 1'b0;
               tmo_cnt_q  <= '0;
               bit_cnt_q  <= '0;
               crc_q      <= '0;
               if (enable_rx) begin
                  // pad_response survives acknowledge and is only cleared here.
                  long_q    <= long_response;
                  shift_q   <= '0;
                  pad_q     <= '0;
                  crc_err_q <= 1'b0;
                  busy_q    <= 1'b1;
                  state_q   <= WAIT_START;
               end
            end

            WAIT_START: begin
               if (!enable_rx) begin
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end else if (!cmd_pin_in) begin
                  // Start bit wins even on the edge the timeout would expire.
                  shift_q   <= shift_d;
                  crc_q     <= crc_d;
                  bit_cnt_q <= bit_num_d;
                  state_q   <= RECEIVE;
               end else if (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
                  no_resp_q <= 1'b1;
                  busy_q    <= 1'b0;
                  state_q   <= DONE;
               end else begin
                  tmo_cnt_q <= tmo_cnt_q + 1'b1;
               end
            end

            RECEIVE: begin
               if (!enable_rx) begin
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end else begin
                  shift_q   <= shift_d;
                  crc_q     <= crc_d;
                  bit_cnt_q <= bit_num_d;
                  if (bit_num_d == frame_len) begin
                     pend_q  <= 1'b1;
                     busy_q  <= 1'b0;
                     state_q <= DONE;
                  end
               end
            end

            DONE: begin
               if (!enable_rx) begin
                  complete_q <= 1'b0;
                  no_resp_q  <= 1'b0;
                  pend_q     <= 1'b0;
                  state_q    <= IDLE;
               end else if (pend_q) begin
                  pend_q     <= 1'b0;
                  complete_q <= 1'b1;
                  pad_q      <= shift_q;
                  crc_err_q  <= (crc_q != shift_q[7:1]) | ~shift_q[0];
               end
            end

            default: state_q <= IDLE;
         endcase
      end
   end

   assign pad_response       = pad_q;
   assign reception_complete = complete_q;
   assign no_response        = no_resp_q;
   assign crc_error          = crc_err_q;
   assign busy               = busy_q;

endmodule

// File: tb/tb_cmd_pad_receiver.sv
`timescale 1ns/1ps
// Bench for cmd_pad_receiver: directed frames, a frame-level reference model
// (bit queue + polynomial-division CRC7) compared every cycle, and literal
// expectations pinning the key timing points and CRC values.
module tb_cmd_pad_receiver;

   localparam int TMO = 64;
   localparam int SB  = 48;
   localparam int LB  = 136;

   logic          sd_clock;
   logic          reset;
   logic          enable_rx;
   logic          long_response;
   logic          cmd_pin_in;
   logic [LB-1:0] pad_response;
   logic          reception_complete;
   logic          no_response;
   logic          crc_error;
   logic          busy;

   int tests = 0;
   int fails = 0;
   bit chk_en = 0;

   cmd_pad_receiver #(.TIMEOUT_CYCLES(TMO), .SHORT_BITS(SB), .LONG_BITS(LB)) dut (
      .sd_clock           (sd_clock),
      .reset              (reset),
      .enable_rx          (enable_rx),
      .long_response      (long_response),
      .cmd_pin_in         (cmd_pin_in),
      .pad_response       (pad_response),
      .reception_complete (reception_complete),
      .no_response        (no_response),
      .crc_error          (crc_error),
      .busy               (busy)
   );

   // ---------------- clock ----------------
   initial sd_clock = 1'b0;
   always #5 sd_clock = ~sd_clock;

   // ---------------- helpers ----------------
   task automatic check(input string nm, input logic [LB-1:0] got, input logic [LB-1:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
      end
   endtask

   // CRC7 as the remainder of M(x)*x^7 divided by x^7+x^3+1, where M is
   // f[top:bot] taken MSB first.
   function automatic logic [6:0] crc7(input logic [LB-1:0] f, input int top, input int bot);
      logic [7:0] r;
      r = 8'h00;
      for (int i = top; i >= bot - 7; i--) begin
         r = {r[6:0], (i >= bot) ? f[i] : 1'b0};
         if (r[7]) r = r ^ 8'h89;
      end
      return r[6:0];
   endfunction

   // ---------------- reference model ----------------
   logic [LB-1:0] exp_pad;
   logic          exp_complete, exp_nr, exp_crc_err, exp_busy;
   bit            m_armed, m_done, m_pend, m_long;
   int            m_highs, m_n;
   bit            m_bits[$];
   logic [LB-1:0] m_frame;

   always @(posedge sd_clock or negedge reset) begin
      if (!reset) begin
         exp_pad = '0; exp_complete = 0; exp_nr = 0; exp_crc_err = 0; exp_busy = 0;
         m_armed = 0; m_done = 0; m_pend = 0; m_long = 0; m_highs = 0;
         m_bits.delete();
      end else begin
         if (m_done) begin
            if (!enable_rx) begin
               m_done = 0; m_pend = 0; exp_complete = 0; exp_nr = 0;
            end else if (m_pend) begin
               m_pend       = 0;
               exp_complete = 1;
               exp_pad      = m_frame;
               exp_crc_err  = (crc7(m_frame, m_long ? 127 : SB - 1, 8) != m_frame[7:1]) || !m_frame[0];
            end
         end else if (!m_armed) begin
            if (enable_rx) begin
               m_armed = 1; m_long = long_response; m_n = long_response ? LB : SB;
               m_highs = 0; m_bits.delete(); exp_pad = '0; exp_crc_err = 0;
            end
         end else if (!enable_rx) begin
            m_armed = 0;
         end else if (m_bits.size() == 0 && cmd_pin_in) begin
            m_highs++;
            if (m_highs == TMO) begin
               m_armed = 0; m_done = 1; exp_nr = 1;
            end
         end else begin
            m_bits.push_back(cmd_pin_in);
            if (m_bits.size() == m_n) begin
               m_frame = '0;
               for (int i = 0; i < m_n; i++) m_frame[m_n - 1 - i] = m_bits[i];
               m_armed = 0; m_done = 1; m_pend = 1;
            end
         end
         exp_busy = m_armed;
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge sd_clock) begin
      if (reset && chk_en) begin
         check("m_busy",     busy,               exp_busy);
         check("m_complete", reception_complete, exp_complete);
         check("m_no_resp",  no_response,        exp_nr);
         check("m_crc_err",  crc_error,          exp_crc_err);
         check("m_pad",      pad_response,       exp_pad);
      end
   end

   // ---------------- driver tasks ----------------
   // cut_mode: 0 = full frame, 1 = drop enable_rx at bit cut_at, 2 = reset at bit cut_at
   task automatic run_frame(input logic [LB-1:0] f, input bit lng, input bit exp_err,
                            input int cut_mode, input int cut_at);
      int  n;
      bit  cut;
      n   = lng ? LB : SB;
      cut = 0;
      enable_rx     = 1'b1;
      long_response = lng;
      cmd_pin_in    = 1'b1;
      @(negedge sd_clock);
      long_response = ~lng;          // must be ignored once armed
      repeat (5) @(negedge sd_clock);
      for (int i = 0; i < n && !cut; i++) begin
         if (cut_mode == 1 && i == cut_at - 1) begin
            enable_rx  = 1'b0;
            cmd_pin_in = 1'b1;
            @(negedge sd_clock);
            check("abort_busy",     busy,               1'b0);
            check("abort_complete", reception_complete, 1'b0);
            check("abort_pad",      pad_response,       '0);
            @(negedge sd_clock);
            cut = 1;
         end else if (cut_mode == 2 && i == cut_at - 1) begin
            cmd_pin_in = f[n - 1 - i];
            #2;
            reset     = 1'b0;
            enable_rx = 1'b0;
            #1;
            check("rst_busy",     busy,               1'b0);
            check("rst_complete", reception_complete, 1'b0);
            check("rst_no_resp",  no_response,        1'b0);
            check("rst_crc_err",  crc_error,          1'b0);
            check("rst_pad",      pad_response,       '0);
            @(negedge sd_clock);
            reset = 1'b1;
            @(negedge sd_clock);
            cut = 1;
         end else begin
            cmd_pin_in = f[n - 1 - i];
            @(negedge sd_clock);
         end
      end
      if (!cut) begin
         cmd_pin_in = 1'b1;
         check("complete_early", reception_complete, 1'b0);
         @(negedge sd_clock);
         check("complete", reception_complete, 1'b1);
         check("pad",      pad_response,       f);
         check("crc_err",  crc_error,          exp_err);
         enable_rx = 1'b0;
         @(negedge sd_clock);
         check("ack_complete", reception_complete, 1'b0);
         check("pad_hold",     pad_response,       f);
         @(negedge sd_clock);
      end
   endtask

   task automatic run_timeout();
      enable_rx  = 1'b1;
      cmd_pin_in = 1'b1;
      @(negedge sd_clock);             // edge 1: arm
      repeat (63) @(negedge sd_clock); // edges 2..64
      check("nr_early", no_response, 1'b0);
      @(negedge sd_clock);             // edge 65
      check("nr_set",      no_response,        1'b1);
      check("nr_complete", reception_complete, 1'b0);
      check("nr_busy",     busy,               1'b0);
      enable_rx = 1'b0;
      @(negedge sd_clock);
      check("nr_clear",    no_response,        1'b0);
      check("nr_complete_clear", reception_complete, 1'b0);
      @(negedge sd_clock);
   endtask

   // ---------------- main ----------------
   logic [LB-1:0] long_f;

   initial begin
      reset = 1'b0; enable_rx = 1'b0; long_response = 1'b0; cmd_pin_in = 1'b1;
      repeat (3) @(negedge sd_clock);
      check("reset_pad",      pad_response,       '0);
      check("reset_complete", reception_complete, 1'b0);
      check("reset_no_resp",  no_response,        1'b0);
      check("reset_crc_err",  crc_error,          1'b0);
      check("reset_busy",     busy,               1'b0);
      reset  = 1'b1;
      chk_en = 1;
      @(negedge sd_clock);

      // Pin the model's CRC against known command CRCs.
      check("crc_cmd0", crc7(136'h4000000000, 39, 0), 7'h4A);
      check("crc_cmd8", crc7(136'h48000001AA, 39, 0), 7'h43);

      run_frame(136'h400000000095, 1'b0, 1'b0, 0, 0);
      run_frame(136'h48000001AA87, 1'b0, 1'b0, 0, 0);
      run_frame(136'h400000000097, 1'b0, 1'b1, 0, 0);
      run_frame(136'h400000000094, 1'b0, 1'b1, 0, 0);
      run_timeout();

      long_f = {8'h3F, 120'h0123456789ABCDEFFEDCBA98765432, 8'h00};
      long_f[7:1] = crc7(long_f, 127, 8);
      long_f[0]   = 1'b1;
      run_frame(long_f, 1'b1, 1'b0, 0, 0);

      run_frame(136'h48000001AA87, 1'b0, 1'b0, 1, 20);
      run_frame(136'h400000000095, 1'b0, 1'b0, 2, 30);
      run_frame(136'h48000001AA87, 1'b0, 1'b0, 0, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

endmodule
